// File: rtl/clock_pkg.sv
// Shared constants for the minute/second binary-to-BCD converter.
package clock_pkg;

  localparam int unsigned DIGIT_W     = 4;
  localparam int unsigned SHIFT_STEPS = 6;

  localparam logic [DIGIT_W-1:0] BCD_BLANK = 4'hF;

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StShift = 1'b1;

endpackage

// File: rtl/bcd_dabble6.sv
// Sequential shift-add-3 converter: 6-bit binary into tens/ones digits, one step per enable.
module bcd_dabble6
  import clock_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [5:0]         bin_i,
  output logic [DIGIT_W-1:0] tens_next_o,
  output logic [DIGIT_W-1:0] ones_next_o
);

  logic [5:0]         bin_q, bin_d;
  logic [DIGIT_W-1:0] tens_q, tens_d, ones_q, ones_d;
  logic [DIGIT_W-1:0] tens_adj, ones_adj;

  // Outputs are the digits after the current step, so the caller can load them on the final edge.
  always_comb begin
    tens_adj    = (tens_q >= DIGIT_W'(5)) ? tens_q + DIGIT_W'(3) : tens_q;
    ones_adj    = (ones_q >= DIGIT_W'(5)) ? ones_q + DIGIT_W'(3) : ones_q;
    tens_next_o = {tens_adj[DIGIT_W-2:0], ones_adj[DIGIT_W-1]};
    ones_next_o = {ones_adj[DIGIT_W-2:0], bin_q[5]};
  end

  always_comb begin
    bin_d  = bin_q;
    tens_d = tens_q;
    ones_d = ones_q;
    if (load_i) begin
      bin_d  = bin_i;
      tens_d = '0;
      ones_d = '0;
    end else if (step_i) begin
      bin_d  = {bin_q[4:0], 1'b0};
      tens_d = tens_next_o;
      ones_d = ones_next_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bin_q  <= '0;
      tens_q <= '0;
      ones_q <= '0;
    end else begin
      bin_q  <= bin_d;
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

endmodule

// File: rtl/time_bcd_convert.sv
// Converts binary minute/second into four BCD display digits over six shift cycles.
module time_bcd_convert
  import clock_pkg::*;
#(
  parameter bit BLANK_LEADING = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  minute,
  input  logic [5:0]  second,
  input  logic        start,
  output logic [15:0] bcd,
  output logic        busy,
  output logic        done,
  output logic        err
);

  logic [0:0]         state_q, state_d;
  logic [2:0]         count_q, count_d;
  logic [15:0]        bcd_q, bcd_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               load, step, last;
  logic [DIGIT_W-1:0] min_tens, min_ones, sec_tens, sec_ones, min_tens_disp;

  assign load = (state_q == StIdle) && start;
  assign step = (state_q == StShift);
  assign last = step && (count_q == 3'(SHIFT_STEPS - 1));

  bcd_dabble6 u_min (
    .clk_i       (clock),
    .rst_i       (reset),
    .load_i      (load),
    .step_i      (step),
    .bin_i       (minute),
    .tens_next_o (min_tens),
    .ones_next_o (min_ones)
  );

  bcd_dabble6 u_sec (
    .clk_i       (clock),
    .rst_i       (reset),
    .load_i      (load),
    .step_i      (step),
    .bin_i       (second),
    .tens_next_o (sec_tens),
    .ones_next_o (sec_ones)
  );

  assign min_tens_disp = (BLANK_LEADING && (min_tens == '0)) ? BCD_BLANK : min_tens;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StShift;
          count_d = '0;
        end
      end
      StShift: begin
        count_d = count_q + 3'd1;
        if (last) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Tens digit of 6 can only come from an out-of-range 60..63 input.
  always_comb begin
    done_d = last;
    bcd_d  = bcd_q;
    err_d  = err_q;
    if (last) begin
      bcd_d = {min_tens_disp, min_ones, sec_tens, sec_ones};
      err_d = (min_tens > DIGIT_W'(5)) || (sec_tens > DIGIT_W'(5));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      count_q <= '0;
      bcd_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      bcd_q   <= bcd_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bcd  = bcd_q;
  assign busy = (state_q == StShift);
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_time_bcd_convert.sv
// Directed bench for time_bcd_convert; runs a plain and a leading-blank instance side by side.
module tb_time_bcd_convert;

  logic        clock;
  logic        reset;
  logic [5:0]  minute;
  logic [5:0]  second;
  logic        start;
  logic [15:0] bcd0, bcd1;
  logic        busy0, busy1, done0, done1, err0, err1;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [15:0] last_exp;

  time_bcd_convert #(.BLANK_LEADING(1'b0)) dut0 (
    .clock  (clock),
    .reset  (reset),
    .minute (minute),
    .second (second),
    .start  (start),
    .bcd    (bcd0),
    .busy   (busy0),
    .done   (done0),
    .err    (err0)
  );

  time_bcd_convert #(.BLANK_LEADING(1'b1)) dut1 (
    .clock  (clock),
    .reset  (reset),
    .minute (minute),
    .second (second),
    .start  (start),
    .bcd    (bcd1),
    .busy   (busy1),
    .done   (done1),
    .err    (err1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] blanked(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    if (v[15:12] == 4'h0) r[15:12] = 4'hF;
    return r;
  endfunction

  // Starts a conversion at the current negedge and returns in the done cycle.
  task automatic conv(input string tag, input logic [5:0] m, input logic [5:0] s,
                      input logic [15:0] exp_bcd, input logic exp_err);
    int lat;
    int busy_cnt;
    bit hold_bad;
    bit overlap;
    minute = m;
    second = s;
    start  = 1'b1;
    @(negedge clock);
    start    = 1'b0;
    lat      = 1;
    busy_cnt = 0;
    hold_bad = 1'b0;
    overlap  = 1'b0;
    while (!done0 && lat < 20) begin
      if (busy0) busy_cnt++;
      if (bcd0 !== last_exp) hold_bad = 1'b1;
      @(negedge clock);
      lat++;
    end
    if (busy0 && done0) overlap = 1'b1;
    check({tag, " latency"}, 32'(lat), 32'd7);
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'd6);
    check({tag, " bcd_hold"}, 32'(hold_bad), 32'd0);
    check({tag, " busy_done_overlap"}, 32'(overlap), 32'd0);
    check({tag, " bcd"}, 32'(bcd0), 32'(exp_bcd));
    check({tag, " err"}, 32'(err0), 32'(exp_err));
    check({tag, " done_blank"}, 32'(done1), 32'd1);
    check({tag, " bcd_blank"}, 32'(bcd1), 32'(blanked(exp_bcd)));
    check({tag, " err_blank"}, 32'(err1), 32'(exp_err));
    last_exp = exp_bcd;
  endtask

  initial begin
    int dcnt;
    int dlat;
    reset    = 1'b1;
    start    = 1'b1;
    minute   = 6'd45;
    second   = 6'd7;
    last_exp = 16'h0000;
    repeat (3) @(negedge clock);
    check("reset bcd", 32'(bcd0), 32'h0);
    check("reset busy", 32'(busy0), 32'd0);
    check("reset done", 32'(done0), 32'd0);
    check("reset err", 32'(err0), 32'd0);
    check("reset bcd_blank", 32'(bcd1), 32'h0);

    // Start held across reset release must be taken on the very first free edge.
    reset = 1'b0;
    conv("c4507", 6'd45, 6'd7, 16'h4507, 1'b0);
    @(negedge clock);
    check("c4507 done_pulse", 32'(done0), 32'd0);
    check("c4507 bcd_stable", 32'(bcd0), 32'h4507);

    conv("c5959", 6'd59, 6'd59, 16'h5959, 1'b0);
    @(negedge clock);
    conv("c0000", 6'd0, 6'd0, 16'h0000, 1'b0);
    @(negedge clock);
    conv("c6210", 6'd62, 6'd10, 16'h6210, 1'b1);
    @(negedge clock);
    check("c6210 err_held", 32'(err0), 32'd1);
    conv("c1234", 6'd12, 6'd34, 16'h1234, 1'b0);
    @(negedge clock);

    // Start pulses during SHIFT carrying other operands must be ignored.
    minute = 6'd23;
    second = 6'd8;
    start  = 1'b1;
    dcnt   = 0;
    dlat   = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clock);
      if (i == 1) start = 1'b0;
      if (i == 3) begin
        minute = 6'd50;
        second = 6'd51;
        start  = 1'b1;
      end
      if (i == 5) start = 1'b0;
      if (done0) begin
        dcnt++;
        if (dcnt == 1) dlat = i;
      end
    end
    check("ignore done_count", 32'(dcnt), 32'd1);
    check("ignore latency", 32'(dlat), 32'd7);
    check("ignore bcd", 32'(bcd0), 32'h2308);
    check("ignore bcd_blank", 32'(bcd1), 32'h2308);
    last_exp = 16'h2308;

    // Second start issued in the done cycle of the first.
    conv("b2b_first", 6'd7, 6'd3, 16'h0703, 1'b0);
    conv("b2b_second", 6'd38, 6'd41, 16'h3841, 1'b0);
    @(negedge clock);
    conv("c6360", 6'd63, 6'd60, 16'h6360, 1'b1);
    @(negedge clock);

    // Reset at edge k+3 aborts the conversion.
    minute = 6'd45;
    second = 6'd7;
    start  = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort busy", 32'(busy0), 32'd0);
    check("abort done", 32'(done0), 32'd0);
    check("abort bcd", 32'(bcd0), 32'h0);
    check("abort err", 32'(err0), 32'd0);
    dcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (done0 || done1) dcnt++;
    end
    check("abort no_done", 32'(dcnt), 32'd0);
    check("abort bcd_after", 32'(bcd0), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/time_bcd_convert.md
TIME_BCD_CONVERT -- requirements
Module: time_bcd_convert

Interface
REQ-001 SHALL have parameter BLANK_LEADING, default 0: when 1, a minute-tens digit equal to 0 is output as the blank code 4'hF.
REQ-002 SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port minute, input, 6 bits: binary minutes from the timekeeping counters.
REQ-005 SHALL have port second, input, 6 bits: binary seconds from the timekeeping counters.
REQ-006 SHALL have port start, input, 1 bit: conversion request, sampled only in IDLE.
REQ-007 SHALL have port bcd, output, 16 bits: {min_tens, min_ones, sec_tens, sec_ones}, one 4-bit digit each, feeding the segment display data input.
REQ-008 SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when bcd updates.
REQ-010 SHALL have port err, output, 1 bit: the last accepted input had minute>59 or second>59.

Function
REQ-011 SHALL implement the FSM states IDLE and SHIFT only; reset enters IDLE.
REQ-012 SHALL, when start=1 in IDLE at edge k, capture minute and second into internal shift registers, clear the BCD accumulators and the shift count, and enter SHIFT.
REQ-013 SHALL perform one shift-add-3 step per cycle on minute and second in parallel: add 3 to any digit >=5, then shift left 1.
REQ-014 SHALL complete in exactly 6 SHIFT cycles (edges k+1..k+6) and return to IDLE at edge k+6.
REQ-015 SHALL load bcd at edge k+6 and hold it stable until the next completed conversion.
REQ-016 SHALL drive done=1 only in the cycle following edge k+6.
REQ-017 SHALL drive busy=1 from the cycle after edge k through the cycle before done rises; busy and done are never both high.
REQ-018 SHALL ignore start while busy=1, with no queuing and no effect on the conversion in progress.
REQ-019 SHALL accept start in the same cycle done=1 (state is IDLE); the new conversion does not disturb bcd until its own completion.
REQ-020 SHALL convert out-of-range values 60..63 arithmetically (tens=6) and set err at edge k+6; err holds until the next completion, which sets or clears it.
REQ-021 SHALL, with BLANK_LEADING=1, replace bcd[15:12]=0 with 4'hF at load time; all other digits are never blanked.
REQ-022 SHALL keep each digit accumulator 4 bits wide; no result exceeds 6 in any tens digit or 9 in any ones digit.

Reset
REQ-023 SHALL, when reset=1 at a rising edge, set state=IDLE, bcd=16'h0000, busy=0, done=0, err=0, and clear the shift registers and count.
REQ-024 SHALL abort an in-progress conversion on reset, with no done pulse and no bcd update.
REQ-025 SHALL take reset priority over start in the same cycle.
REQ-026 SHALL accept start in the first cycle after reset deasserts.

Structure
REQ-027 SHALL place the state encoding, BCD_BLANK=4'hF and DIGIT_W=4 in the shared package clock_pkg.
REQ-028 SHALL implement the per-value shift-add-3 datapath (6-bit binary in, 2 digits out, one step per enable) as sub-module bcd_dabble6, instantiated twice (minutes, seconds).
REQ-029 SHALL keep the FSM, count, output registers, blanking and err logic in time_bcd_convert.

Verification
REQ-030 SHALL cover: reset, then minute=45, second=7, start pulse at edge k -> busy for 6 cycles, done in the cycle after edge k+6, bcd=16'h4507, err=0.
REQ-031 SHALL cover: minute=59, second=59 -> bcd=16'h5959; then minute=0, second=0 -> bcd=16'h0000, or 16'hF000 with BLANK_LEADING=1.
REQ-032 SHALL cover: minute=62, second=10 -> bcd=16'h6210, err=1; the next conversion with 12:34 -> bcd=16'h1234, err=0.
REQ-033 SHALL cover: start during SHIFT with different inputs -> ignored, first result delivered unchanged, single done pulse.
REQ-034 SHALL cover: back-to-back start asserted in the done cycle -> second conversion completes 6 cycles later with its own result.
REQ-035 SHALL cover: reset asserted at edge k+3 of a conversion -> no done pulse, bcd=16'h0000, busy=0 in the next cycle.
